// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, en-paced shift-out,
// one-cycle done pulse, line idles high.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head;

  assign head = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last bit is left in place on the final en edge; DONE drives the line high anyway.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b1;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE:  load_ready = 1'b1;
      SHIFT: begin
        sout       = head;
        sout_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: load_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances driven in lockstep,
// expected bit pairs queued at issue time and popped by a negedge monitor.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset, load_valid, en;
  logic [7:0] din;

  logic m_ready, m_sout, m_sv, m_busy, m_done;
  logic l_ready, l_sout, l_sv, l_busy, l_done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // {msb_first_bit, lsb_first_bit} per enabled bit slot
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid), .load_ready(m_ready),
    .en(en), .sout(m_sout), .sout_valid(m_sv), .busy(m_busy), .done(m_done)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid), .load_ready(l_ready),
    .en(en), .sout(l_sout), .sout_valid(l_sv), .busy(l_busy), .done(l_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string nm, input logic rdy, input logic sv,
                         input logic bsy, input logic dn);
    chk({nm, ".m.ready"}, m_ready, rdy);
    chk({nm, ".m.sv"},    m_sv,    sv);
    chk({nm, ".m.busy"},  m_busy,  bsy);
    chk({nm, ".m.done"},  m_done,  dn);
    chk({nm, ".l.ready"}, l_ready, rdy);
    chk({nm, ".l.sv"},    l_sv,    sv);
    chk({nm, ".l.busy"},  l_busy,  bsy);
    chk({nm, ".l.done"},  l_done,  dn);
  endtask

  task automatic idle_chk(input string nm);
    chk_dut(nm, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({nm, ".m.sout"}, m_sout, 1'b1);
    chk({nm, ".l.sout"}, l_sout, 1'b1);
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int k = 0; k < 8; k++) exp_q.push_back({w[7-k], w[k]});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Full-rate word: accept edge N, bits after N..N+7, done after N+8, ready after N+9.
  task automatic run_word(input logic [7:0] w);
    load_valid = 1'b1; din = w; en = 1'b1;
    push_word(w);
    nxt();
    load_valid = 1'b0; din = ~w;
    chk_dut("acc", 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      nxt();
      chk_dut($sformatf("run%0h_%0d", w, i), i == 9, i < 8, i < 9, i == 8);
    end
  endtask

  // Monitor: every data-carrying cycle must match the queue head; pop on an en edge.
  always @(negedge clk) begin
    logic [1:0] e;
    chk("excl.m", m_done & m_sv, 1'b0);
    chk("excl.l", l_done & l_sv, 1'b0);
    if (m_done === 1'b1) done_cnt++;
    if (m_sv === 1'b1 || l_sv === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sout_unexpected: got sv=%b/%b want no data at %0t", m_sv, l_sv, $time);
      end else begin
        e = exp_q[0];
        chk("sout.m", m_sout, e[1]);
        chk("sout.l", l_sout, e[0]);
        if (en) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a word offered: nothing may be accepted.
    reset = 1'b1; load_valid = 1'b1; din = 8'hFF; en = 1'b1;
    repeat (2) begin
      nxt();
      idle_chk("rst");
    end
    reset = 1'b0; load_valid = 1'b0;
    nxt();
    idle_chk("post_rst");

    run_word(8'h1E);

    // Gapped enable: en on every 3rd edge, bits held in between.
    begin
      int n = 0;
      load_valid = 1'b1; din = 8'hA5; en = 1'b0;
      push_word(8'hA5);
      nxt();
      load_valid = 1'b0; din = 8'h00;
      for (int c = 0; c < 24; c++) begin
        en = (c % 3 == 2);
        nxt();
        if (en) n++;
        chk_dut($sformatf("gap%0d", c), 1'b0, n < 8, 1'b1, n == 8);
      end
      en = 1'b0;
      nxt();
      idle_chk("gap_end");
    end

    // Back-to-back: second word waits for the first IDLE edge.
    load_valid = 1'b1; din = 8'h1E; en = 1'b1;
    push_word(8'h1E);
    push_word(8'hE1);
    nxt();
    din = 8'hE1;
    for (int i = 1; i <= 19; i++) begin
      nxt();
      chk_dut($sformatf("b2b%0d", i), i == 9 || i == 19,
              i < 8 || (i >= 10 && i < 18), i != 9 && i != 19, i == 8 || i == 18);
      if (i == 8 || i == 9) begin
        chk("b2b.m.sout_hi", m_sout, 1'b1);
        chk("b2b.l.sout_hi", l_sout, 1'b1);
      end
      if (i == 10) begin
        load_valid = 1'b0; din = 8'h55;
      end
    end

    // Reset mid-word after four bits; remainder is discarded.
    load_valid = 1'b1; din = 8'hFF; en = 1'b1;
    push_word(8'hFF);
    nxt();
    load_valid = 1'b0;
    repeat (4) nxt();
    reset = 1'b1;
    nxt();
    exp_q.delete();
    reset = 1'b0;
    idle_chk("midrst");
    nxt();
    idle_chk("midrst_nodone");

    run_word(8'h0F);

    nxt();
    chk("done_count", done_cnt, 5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter for the flip-flop library. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled cycle on a single serial line. An external `en` strobe paces the bits, so the line can run at a divided rate. This is the sending end of a serial link whose receiving end is a chain of D flip-flops capturing `sout`.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1  positive-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `din`  in  WIDTH  parallel word; sampled only on the accept edge.
- `load_valid`  in  1  source has a word on `din`.
- `load_ready`  out  1  block can accept a word (IDLE only).
- `en`  in  1  bit-advance strobe; ignored outside SHIFT.
- `sout`  out  1  serial data; idles high.
- `sout_valid`  out  1  `sout` carries a data bit.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- State machine: IDLE, SHIFT, DONE. State, shift register and bit counter are all registered; every output is decoded from registers only.
- Reset has priority over everything. On any edge with `reset`=1:
  - state goes to IDLE, the counter clears and the shift register clears;
  - a word in flight is discarded;
  - from that edge until the next accept: `load_ready`=1, `sout`=1, `sout_valid`=0, `busy`=0, `done`=0.
- IDLE:
  - `load_ready`=1, `sout`=1, `sout_valid`=0.
  - Accept = `load_valid` & `load_ready` at a rising edge. On accept, `din` loads into the shift register, the counter clears and the state goes to SHIFT.
  - With `load_valid`=0, the state stays in IDLE.
- SHIFT:
  - `load_ready`=0, `sout_valid`=1, `busy`=1.
  - `sout` is the current head bit: the MSB of the register when MSB_FIRST=1, the LSB when MSB_FIRST=0.
  - On an edge with `en`=1 and counter < WIDTH-1: the register shifts one position toward the head, and the counter increments.
  - On an edge with `en`=1 and counter = WIDTH-1: the state goes to DONE.
  - On an edge with `en`=0: nothing changes, and the current bit is held on `sout` indefinitely.
- DONE: `done`=1, `busy`=1, `sout`=1, `sout_valid`=0, `load_ready`=0. The state goes unconditionally to IDLE on the next edge.
- `load_valid` outside IDLE is ignored, and no word is captured. A source that holds `load_valid` high is accepted on the first IDLE edge.
- Changes on `din` after the accept edge have no effect on the word being sent.
- Counter width is $clog2(WIDTH). The counter never wraps within a word.

## Timing
- Accept at edge N. The first bit appears on `sout` after edge N, i.e. in cycle N+1. Latency from accept to the first bit is 1 cycle.
- With `en` held at 1, bit k (0-based in send order) is on `sout` in cycle N+1+k.
- With `en` held at 1:
  - `done` is high in cycle N+1+WIDTH;
  - `load_ready` returns to 1 in cycle N+2+WIDTH;
  - the earliest next accept is at the end of cycle N+2+WIDTH.
- Full throughput is therefore WIDTH bits per WIDTH+2 cycles.
- With a gapped `en`, each bit lasts from the edge it is presented until the first subsequent edge with `en`=1.
- `done` is high for exactly one cycle per word. `done` and `sout_valid` are never high together.
- Reset asserted in any state, mid-word included, gives IDLE outputs in the cycle after the reset edge. A `load_valid` present on the reset edge is not accepted.

## Test plan
- Reset and idle: assert `reset` for 2 cycles with `load_valid`=1 and `din`=8'hFF, then deassert `reset` with `load_valid`=0. Required:
  - `load_ready`=1, `sout`=1, `sout_valid`=0, `busy`=0, `done`=0;
  - no accept occurs during reset.
- MSB first: WIDTH=8, MSB_FIRST=1, `din`=8'h1E accepted at edge N, `en`=1 throughout. Required:
  - `sout` in cycles N+1..N+8 = 0,0,0,1,1,1,1,0;
  - `done`=1 in cycle N+9 only;
  - `load_ready`=1 from cycle N+10.
- LSB first: WIDTH=8, MSB_FIRST=0, `din`=8'h1E, `en`=1. Required: `sout` = 0,1,1,1,1,0,0,0, then the `done` pulse.
- Gapped enable: WIDTH=8, MSB_FIRST=1, `din`=8'hA5, `en` high every 3rd cycle. Required:
  - each bit of 1,0,1,0,0,1,0,1 is held on `sout` until an `en`=1 edge;
  - `sout_valid`=1 throughout SHIFT;
  - exactly one `done` pulse after the 8th enabled edge.
- Back-to-back loads: `load_valid` held high with `din`=8'h1E, then 8'hE1 presented while busy. Required:
  - the second word is not taken during SHIFT or DONE;
  - it is accepted on the first IDLE edge;
  - the serial stream is 00011110 then 11100001, separated by one DONE cycle and one IDLE cycle of `sout`=1.
- Reset mid-word: accept 8'hFF, assert `reset` after the 4th bit. Required:
  - IDLE outputs in the next cycle, with no `done` pulse;
  - a following accept of 8'h0F shifts all 8 bits, 00001111, from a cleared counter.
